unsigned_div_seq: RTL and testbench

- Iterative radix-2 restoring divider for unsigned operands. It performs the inverse operation of the approximate unsigned multipliers in this library.
- Used by the error-characterization datapath to recover an operand from a product, and as a reference "divide" unit alongside the multipliers.
- Divides a 2N-bit dividend by an N-bit divisor and returns a 2N-bit quotient and an N-bit remainder.
- Uses valid/ready handshakes on both input and output, one quotient bit per cycle.

---
 rtl/unsigned_div_pkg.sv | 33 +++
 rtl/unsigned_div_step.sv | 19 +
 rtl/unsigned_div_seq.sv | 109 ++++++++++
 tb/tb_unsigned_div_seq.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/unsigned_div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
// APPROX_TRUNC_EN selects the truncated-dividend variant.
package unsigned_div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

`ifdef APPROX_TRUNC_EN
   localparam bit APPROX = 1'b1;
`else
   localparam bit APPROX = 1'b0;
`endif

   localparam int DEF_N     = 8;
   localparam int DEF_TRUNC = 4;

   // Dividend LSBs that never enter the datapath.
   function automatic int trunc_bits(int trunc);
      return APPROX ? trunc : 0;
   endfunction

   function automatic int iter_count(int n, int trunc);
      return 2 * n - trunc_bits(trunc);
   endfunction

   function automatic int cnt_width(int n);
      return $clog2(2 * n + 1);
   endfunction

endpackage

// File: rtl/unsigned_div_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// subtract the divisor when it fits.
module unsigned_div_step #(
   parameter int N = 8
) (
   input  logic [N:0]   rem,
   input  logic         next_bit,
   input  logic [N-1:0] divisor,
   output logic [N:0]   rem_next,
   output logic         q_bit
);

   logic [N+1:0] wide;

   assign wide     = {rem, next_bit};
   assign q_bit    = (wide >= {2'b00, divisor});
   assign rem_next = q_bit ? (N+1)'(wide - {2'b00, divisor}) : wide[N:0];

endmodule

// File: rtl/unsigned_div_seq.sv
// Radix-2 restoring unsigned divider, one quotient bit per cycle, with
// valid/ready on both sides. APPROX_TRUNC_EN drops TRUNC dividend LSBs.
//
// state | meaning
// IDLE  | in_ready high, waiting for operands
// BUSY  | one restoring step per cycle until the counter hits 1
// DONE  | result held with out_valid high until out_ready
module unsigned_div_seq
   import unsigned_div_pkg::*;
#(
   parameter int N     = DEF_N,
   parameter int TRUNC = DEF_TRUNC
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [2*N-1:0] dividend,
   input  logic [N-1:0]   divisor,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*N-1:0] quotient,
   output logic [N-1:0]   remainder,
   output logic           div_by_zero
);

   localparam int SHIFT = trunc_bits(TRUNC);
   localparam int ITERS = iter_count(N, TRUNC);
   localparam int CW    = cnt_width(N);

   state_t         state;
   logic [CW-1:0]  count;
   logic [2*N-1:0] work;
   logic [N:0]     partial;
   logic [N-1:0]   dvsr;

   logic [N:0]     rem_next;
   logic           q_bit;
   logic [2*N-1:0] next_work;

   unsigned_div_step #(.N(N)) u_step (
      .rem      (partial),
      .next_bit (work[2*N-1]),
      .divisor  (dvsr),
      .rem_next (rem_next),
      .q_bit    (q_bit)
   );

   // Dividend bits leave at the top while quotient bits enter at the bottom.
   assign next_work = {work[2*N-2:0], q_bit};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         in_ready    <= 1'b1;
         out_valid   <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         count       <= '0;
         work        <= '0;
         partial     <= '0;
         dvsr        <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  in_ready <= 1'b0;
                  if (divisor == '0) begin
                     quotient    <= '1;
                     remainder   <= '0;
                     div_by_zero <= 1'b1;
                     out_valid   <= 1'b1;
                     state       <= DONE;
                  end else begin
                     // Truncated LSBs are cleared so the top-aligned walk stops early.
                     work    <= (dividend >> SHIFT) << SHIFT;
                     dvsr    <= divisor;
                     partial <= '0;
                     count   <= CW'(ITERS);
                     state   <= BUSY;
                  end
               end
            end
            BUSY: begin
               work    <= next_work;
               partial <= rem_next;
               count   <= count - CW'(1);
               if (count == CW'(1)) begin
                  quotient  <= next_work << SHIFT;
                  remainder <= rem_next[N-1:0];
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid   <= 1'b0;
                  div_by_zero <= 1'b0;
                  in_ready    <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_unsigned_div_seq.sv
// Scoreboard bench for unsigned_div_seq: driver pushes reference results,
// negedge monitor compares whatever the DUT presents.
module tb_unsigned_div_seq;

   localparam int N     = 8;
   localparam int TRUNC = 4;
`ifdef APPROX_TRUNC_EN
   localparam int DROP = TRUNC;
`else
   localparam int DROP = 0;
`endif

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [2*N-1:0]  dividend = '0;
   logic [N-1:0]    divisor = '0;
   logic            out_valid;
   logic            out_ready = 1'b1;
   logic [2*N-1:0]  quotient;
   logic [N-1:0]    remainder;
   logic            div_by_zero;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      logic        dbz;
      int          lat;
      int          stall;
      int          acc;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   errors = 0;
   int   cyc = 0;
   bit   presented = 1'b0;
   bit   check_idle = 1'b0;
   int   hold = 0;

   unsigned_div_seq #(.N(N), .TRUNC(TRUNC)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dividend    (dividend),
      .divisor     (divisor),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      tests++;
      errors++;
      $display("FAIL %s: bound expired at cycle %0d", name, cyc);
   endtask

   // Reference: plain integer division on the (optionally truncated) dividend.
   function automatic exp_t model(input int x, input int y, input int stall);
      exp_t e;
      int   xs;
      xs = x >> DROP;
      e.stall = stall;
      e.acc   = 0;
      if (y == 0) begin
         e.q = 32'hFFFF; e.r = 0; e.dbz = 1'b1;
         e.lat = 0;               // registered on the accept edge itself
      end else begin
         e.q = (xs / y) << DROP; e.r = xs % y; e.dbz = 1'b0;
         e.lat = 2 * N - DROP;
      end
      return e;
   endfunction

   task automatic wait_ready();
      int waited = 0;
      @(negedge clk);
      while (!in_ready && waited < 300) begin
         @(negedge clk);
         waited++;
      end
   endtask

   task automatic issue(input int x, input int y, input int stall);
      exp_t e;
      wait_ready();
      if (!in_ready) begin
         fail_now("in_ready_timeout");
         return;
      end
      in_valid = 1'b1;
      dividend = x[2*N-1:0];
      divisor  = y[N-1:0];
      @(posedge clk);
      #1;
      e = model(x, y, stall);
      e.acc = cyc;
      sb.push_back(e);
      in_valid = 1'b0;
      dividend = 16'($urandom);
      divisor  = 8'($urandom);
   endtask

   task automatic drain();
      int waited = 0;
      while ((sb.size() != 0 || out_valid) && waited < 2000) begin
         @(negedge clk);
         waited++;
      end
      if (sb.size() != 0 || out_valid) fail_now("drain");
      @(negedge clk);
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         presented  = 1'b0;
         check_idle = 1'b0;
         out_ready  = 1'b1;
      end else begin
         if (check_idle) begin
            check("idle_out_valid", {31'd0, out_valid}, 32'd0);
            check("idle_in_ready", {31'd0, in_ready}, 32'd1);
            check_idle = 1'b0;
         end
         if (out_valid) begin
            if (sb.size() == 0) begin
               fail_now("unexpected_output");
            end else begin
               if (!presented) begin
                  presented = 1'b1;
                  hold = 0;
                  check("latency", cyc - sb[0].acc, sb[0].lat);
               end
               check("quotient", {16'd0, quotient}, sb[0].q);
               check("remainder", {24'd0, remainder}, sb[0].r);
               check("div_by_zero", {31'd0, div_by_zero}, {31'd0, sb[0].dbz});
               check("busy_in_ready", {31'd0, in_ready}, 32'd0);
               if (hold < sb[0].stall) begin
                  out_ready = 1'b0;
                  hold++;
               end else begin
                  out_ready = 1'b1;
                  void'(sb.pop_front());
                  presented  = 1'b0;
                  check_idle = 1'b1;
               end
            end
         end
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      check("reset_in_ready", {31'd0, in_ready}, 32'd1);
      check("reset_out_valid", {31'd0, out_valid}, 32'd0);
      check("reset_quotient", {16'd0, quotient}, 32'd0);
      rst_n = 1'b1;

      issue(1000, 7, 0);
      issue(65535, 255, 0);
      issue(65535, 1, 0);
      issue(1234, 0, 0);
      issue(40000, 3, 10);
      issue(0, 5, 0);
      drain();

      // Abort x=500,y=9 mid-flight; nothing from it may ever appear.
      wait_ready();
      in_valid = 1'b1;
      dividend = 16'd500;
      divisor  = 8'd9;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("abort_out_valid", {31'd0, out_valid}, 32'd0);
      check("abort_in_ready", {31'd0, in_ready}, 32'd1);
      check("abort_remainder", {24'd0, remainder}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      issue(81, 9, 0);
      drain();

      for (int i = 0; i < 40; i++) begin
         int x, y;
         x = int'($urandom_range(0, 65535));
         y = ($urandom_range(0, 7) == 0) ? 0 :
             (($urandom_range(0, 7) == 0) ? 1 : int'($urandom_range(1, 255)));
         issue(x, y, int'($urandom_range(0, 3)));
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
